// File: rtl/store_buffer_coalesce_pkg.sv
// Shared types for the coalescing store buffer.
// Entry fields are sized for the widest configuration; users slice them.
package stb_pkg;

   localparam int STB_AW_MAX = 64;
   localparam int STB_DW_MAX = 128;
   localparam int STB_SW_MAX = STB_DW_MAX / 8;

   typedef struct packed {
      logic [STB_AW_MAX-1:0] addr;
      logic [STB_DW_MAX-1:0] data;
      logic [STB_SW_MAX-1:0] sel;
      logic                  dmem_sel;
   } stb_entry_t;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } stb_state_e;

   function automatic int stb_off_w(input int sel_w);
      return (sel_w > 1) ? $clog2(sel_w) : 0;
   endfunction

endpackage

// File: rtl/store_buffer_coalesce_if.sv
// Store buffer to dcache request bundle.
// The store buffer is the master; the dcache answers with an ack.
interface stb_dcache_if #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int BYTE_SEL_WIDTH = DATA_WIDTH / 8
);
   logic [ADDR_WIDTH-1:0]     stb2dcache_addr;
   logic [DATA_WIDTH-1:0]     stb2dcache_wdata;
   logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte;
   logic                      stb2dcache_w_en;
   logic                      stb2dcache_req;
   logic                      stb2dcache_empty;
   logic                      dmem_sel_o;
   logic                      dcache2stb_ack;

   modport master (
      output stb2dcache_addr,
      output stb2dcache_wdata,
      output stb2dcache_sel_byte,
      output stb2dcache_w_en,
      output stb2dcache_req,
      output stb2dcache_empty,
      output dmem_sel_o,
      input  dcache2stb_ack
   );

   modport slave (
      input  stb2dcache_addr,
      input  stb2dcache_wdata,
      input  stb2dcache_sel_byte,
      input  stb2dcache_w_en,
      input  stb2dcache_req,
      input  stb2dcache_empty,
      input  dmem_sel_o,
      output dcache2stb_ack
   );
endinterface

// File: rtl/store_buffer_coalesce_fwd.sv
// Youngest-first word match over the store buffer entries.
// A match that does not cover every requested byte is a conflict.
module stb_fwd_lookup
   import stb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int BYTE_SEL_WIDTH = DATA_WIDTH / 8,
   parameter int BLEN           = 8,
   parameter int PW             = $clog2(BLEN)
) (
   input  stb_entry_t                ent [BLEN],
   input  logic [BLEN-1:0]           vld,
   input  logic [PW-1:0]             tail,
   input  logic [ADDR_WIDTH-1:0]     ld_addr,
   input  logic [BYTE_SEL_WIDTH-1:0] ld_sel,
   output logic                      hit,
   output logic                      conflict,
   output logic [DATA_WIDTH-1:0]     data
);
   localparam int OFF = stb_off_w(BYTE_SEL_WIDTH);

   logic unused_bits;
   assign unused_bits = ^{ent[0], ld_addr};

   always_comb begin
      int            idx;
      logic [PW-1:0] ix;
      logic          found;
      hit      = 1'b0;
      conflict = 1'b0;
      data     = '0;
      found    = 1'b0;
      idx      = 0;
      ix       = '0;
      for (int k = 1; k <= BLEN; k++) begin
         idx = int'(tail) - k;
         if (idx < 0) idx = idx + BLEN;
         ix = PW'(idx);
         if (!found && vld[ix] &&
             ent[ix].addr[ADDR_WIDTH-1:OFF] == ld_addr[ADDR_WIDTH-1:OFF]) begin
            found = 1'b1;
            if ((ld_sel & ~ent[ix].sel[BYTE_SEL_WIDTH-1:0]) == '0) begin
               hit  = 1'b1;
               data = ent[ix].data[DATA_WIDTH-1:0];
            end else begin
               conflict = 1'b1;
            end
         end
      end
      // An all-zero load select is not a lookup at all
      if (ld_sel == '0) begin
         hit      = 1'b0;
         conflict = 1'b0;
         data     = '0;
      end
   end
endmodule

// File: rtl/store_buffer_coalesce.sv
// Circular store buffer with youngest-entry write coalescing,
// store-to-load forwarding and a req/ack drain to the dcache.
module store_buffer_coalesce
   import stb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int BYTE_SEL_WIDTH = DATA_WIDTH / 8,
   parameter int BLEN           = 8,
   parameter bit COALESCE_EN    = 1'b1,
   parameter bit FWD_EN         = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ADDR_WIDTH-1:0]     lsummu2stb_addr,
   input  logic [DATA_WIDTH-1:0]     lsummu2stb_wdata,
   input  logic [BYTE_SEL_WIDTH-1:0] lsummu2stb_sel_byte,
   input  logic                      lsummu2stb_w_en,
   input  logic                      lsummu2stb_req,
   input  logic                      dmem_sel_i,
   input  logic [ADDR_WIDTH-1:0]     lsummu2stb_ld_addr,
   input  logic [BYTE_SEL_WIDTH-1:0] lsummu2stb_ld_sel,
   output logic                      stb2lsummu_stall,
   output logic                      stb2lsummu_ack,
   output logic [DATA_WIDTH-1:0]     stb2lsummu_fwd_data,
   output logic                      stb2lsummu_fwd_hit,
   output logic                      stb2lsummu_fwd_conflict,
   stb_dcache_if.master              dc
);
   localparam int PW  = $clog2(BLEN);
   localparam int CW  = $clog2(BLEN + 1);
   localparam int OFF = stb_off_w(BYTE_SEL_WIDTH);
   localparam logic [PW-1:0] LAST = PW'(BLEN - 1);
   localparam logic [CW-1:0] FULL = CW'(BLEN);

   stb_entry_t      ent_q [BLEN];
   logic [BLEN-1:0] vld_q;
   logic [PW-1:0]   hd_q, tl_q, yi, wr_idx;
   logic [CW-1:0]   cnt_q;
   stb_state_e      st_q;
   logic            ack_q;
   stb_entry_t      hd_e, wr_e;
   logic            empty, accept, coal, push, pop, word_eq;
   logic            f_hit, f_conf;
   logic [DATA_WIDTH-1:0] f_data;
   logic            unused_hd;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   assign empty            = (cnt_q == '0);
   assign stb2lsummu_stall = (cnt_q == FULL);
   assign stb2lsummu_ack   = ack_q;
   assign accept  = lsummu2stb_req & lsummu2stb_w_en & ~stb2lsummu_stall;
   assign pop     = (st_q == REQ) & dc.dcache2stb_ack;
   assign yi      = (tl_q == '0) ? LAST : tl_q - PW'(1);
   assign word_eq = ent_q[yi].addr[ADDR_WIDTH-1:OFF] ==
                    lsummu2stb_addr[ADDR_WIDTH-1:OFF];
   // The in-flight head must not change under the dcache
   assign coal    = COALESCE_EN && !empty && word_eq &&
                    !((yi == hd_q) && (st_q == REQ));
   assign push    = accept & ~coal;
   assign wr_idx  = coal ? yi : tl_q;

   always_comb begin
      wr_e = '0;
      if (coal) begin
         wr_e = ent_q[yi];
         for (int b = 0; b < BYTE_SEL_WIDTH; b++) begin
            if (lsummu2stb_sel_byte[b])
               wr_e.data[8*b +: 8] = lsummu2stb_wdata[8*b +: 8];
         end
         wr_e.sel[BYTE_SEL_WIDTH-1:0] =
            ent_q[yi].sel[BYTE_SEL_WIDTH-1:0] | lsummu2stb_sel_byte;
      end else begin
         wr_e.addr[ADDR_WIDTH-1:0]     = lsummu2stb_addr;
         wr_e.data[DATA_WIDTH-1:0]     = lsummu2stb_wdata;
         wr_e.sel[BYTE_SEL_WIDTH-1:0]  = lsummu2stb_sel_byte;
         wr_e.dmem_sel                 = dmem_sel_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= '0;
         hd_q  <= '0;
         tl_q  <= '0;
         cnt_q <= '0;
         st_q  <= IDLE;
         ack_q <= 1'b0;
      end else begin
         ack_q <= accept;
         if (accept) ent_q[wr_idx] <= wr_e;
         if (push) begin
            vld_q[tl_q] <= 1'b1;
            tl_q        <= inc(tl_q);
         end
         if (pop) begin
            vld_q[hd_q] <= 1'b0;
            hd_q        <= inc(hd_q);
         end
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
         unique case (st_q)
            IDLE: if (!empty) st_q <= REQ;
            REQ:  if (dc.dcache2stb_ack) st_q <= IDLE;
            default: st_q <= IDLE;
         endcase
      end
   end

   assign hd_e      = ent_q[hd_q];
   assign unused_hd = ^hd_e;

   assign dc.stb2dcache_req      = (st_q == REQ);
   assign dc.stb2dcache_w_en     = (st_q == REQ);
   assign dc.stb2dcache_empty    = empty;
   assign dc.stb2dcache_addr     = empty ? '0 : hd_e.addr[ADDR_WIDTH-1:0];
   assign dc.stb2dcache_wdata    = empty ? '0 : hd_e.data[DATA_WIDTH-1:0];
   assign dc.stb2dcache_sel_byte =
      empty ? '0 : hd_e.sel[BYTE_SEL_WIDTH-1:0];
   assign dc.dmem_sel_o          = empty ? 1'b0 : hd_e.dmem_sel;

   stb_fwd_lookup #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .DATA_WIDTH     (DATA_WIDTH),
      .BYTE_SEL_WIDTH (BYTE_SEL_WIDTH),
      .BLEN           (BLEN),
      .PW             (PW)
   ) u_fwd (
      .ent      (ent_q),
      .vld      (vld_q),
      .tail     (tl_q),
      .ld_addr  (lsummu2stb_ld_addr),
      .ld_sel   (lsummu2stb_ld_sel),
      .hit      (f_hit),
      .conflict (f_conf),
      .data     (f_data)
   );

   assign stb2lsummu_fwd_hit      = FWD_EN ? f_hit  : 1'b0;
   assign stb2lsummu_fwd_conflict = FWD_EN ? f_conf : 1'b0;
   assign stb2lsummu_fwd_data     = FWD_EN ? f_data : '0;
endmodule

// File: tb/tb_store_buffer_coalesce.sv
// Self-checking bench for store_buffer_coalesce: directed scenarios
// plus a randomized FIFO scoreboard with a randomly delayed dcache.
module tb_store_buffer_coalesce;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic        m;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [AW-1:0] st_addr = '0;
   logic [DW-1:0] st_data = '0;
   logic [SW-1:0] st_sel = '0;
   logic          st_wen = 1'b0;
   logic          st_req = 1'b0;
   logic          st_dmem = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [SW-1:0] ld_sel = '0;
   logic          stall, sack, fhit, fconf;
   logic [DW-1:0] fdata;

   logic auto_on = 1'b0;
   logic rsp_ack = 1'b0;
   logic man_ack = 1'b0;
   int   ack_max = 0;

   wr_t got[$];
   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   stb_dcache_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SEL_WIDTH(SW)) dc ();
   assign dc.dcache2stb_ack = rsp_ack | man_ack;

   store_buffer_coalesce #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SEL_WIDTH(SW),
      .BLEN(8), .COALESCE_EN(1'b1), .FWD_EN(1'b1)
   ) dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .lsummu2stb_addr         (st_addr),
      .lsummu2stb_wdata        (st_data),
      .lsummu2stb_sel_byte     (st_sel),
      .lsummu2stb_w_en         (st_wen),
      .lsummu2stb_req          (st_req),
      .dmem_sel_i              (st_dmem),
      .lsummu2stb_ld_addr      (ld_addr),
      .lsummu2stb_ld_sel       (ld_sel),
      .stb2lsummu_stall        (stall),
      .stb2lsummu_ack          (sack),
      .stb2lsummu_fwd_data     (fdata),
      .stb2lsummu_fwd_hit      (fhit),
      .stb2lsummu_fwd_conflict (fconf),
      .dc                      (dc.master)
   );

   // dcache model: acks each request after 0..ack_max cycles, logs writes
   initial begin
      int dly;
      dly = -1;
      forever begin
         @(posedge clk);
         #1;
         if (rsp_ack) begin
            rsp_ack = 1'b0;
            dly = -1;
         end else if (auto_on && dc.stb2dcache_req) begin
            if (dly < 0) dly = int'($urandom_range(0, ack_max));
            if (dly == 0) begin
               rsp_ack = 1'b1;
               got.push_back({dc.stb2dcache_addr, dc.stb2dcache_wdata,
                              dc.stb2dcache_sel_byte, dc.dmem_sel_o});
            end else begin
               dly--;
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic m);
      st_addr = a; st_data = d; st_sel = s; st_dmem = m;
      st_req = 1'b1; st_wen = 1'b1;
      tick();
      st_req = 1'b0; st_wen = 1'b0;
   endtask

   task automatic wait_empty(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 400 && !ok; n++) begin
         tick();
         if (dc.stb2dcache_empty === 1'b1 && dc.stb2dcache_req === 1'b0)
            ok = 1'b1;
      end
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      checks++;
      if ({dc.stb2dcache_empty, dc.stb2dcache_req, stall, sack} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_ctrl got e/r/st/ack=%b want 1000",
                  {dc.stb2dcache_empty, dc.stb2dcache_req, stall, sack});
      end
      checks++;
      if ({dc.stb2dcache_w_en, fhit, fconf} !== 3'b000) begin
         errors++;
         $display("FAIL reset_misc got wen/hit/conf=%b want 000",
                  {dc.stb2dcache_w_en, fhit, fconf});
      end
      checks++;
      if ({dc.stb2dcache_addr, dc.stb2dcache_wdata, dc.stb2dcache_sel_byte,
           dc.dmem_sel_o} !== '0) begin
         errors++;
         $display("FAIL reset_head got addr=%h data=%h want 0",
                  dc.stb2dcache_addr, dc.stb2dcache_wdata);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_fill();
      logic [31:0] d;
      bit acc, ok;
      got.delete(); exp_q.delete(); auto_on = 1'b0;
      for (int i = 0; i < 8; i++) begin
         d = $urandom;
         do_store(32'(i * 4), d, 4'hF, 1'(i % 2));
         exp_q.push_back({32'(i * 4), d, 4'hF, 1'(i % 2)});
         checks++;
         if (sack !== 1'b1) begin
            errors++;
            $display("FAIL fill_ack store %0d got %b want 1", i, sack);
         end
      end
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL fill_stall got %b want 1", stall);
      end
      d = $urandom;
      st_addr = 32'h20; st_data = d; st_sel = 4'hF; st_dmem = 1'b0;
      st_req = 1'b1; st_wen = 1'b1;
      tick();
      checks++;
      if (sack !== 1'b0) begin
         errors++;
         $display("FAIL fill_full_noack got %b want 0", sack);
      end
      auto_on = 1'b1; ack_max = 0;
      acc = 1'b0;
      for (int n = 0; n < 50 && !acc; n++) begin
         tick();
         if (sack === 1'b1) acc = 1'b1;
      end
      st_req = 1'b0; st_wen = 1'b0;
      checks++;
      if (!acc || got.size() < 1) begin
         errors++;
         $display("FAIL fill_9th acc=%b writes_before=%0d want 1 and >=1",
                  acc, got.size());
      end
      exp_q.push_back({32'h20, d, 4'hF, 1'b0});
      wait_empty(ok);
      auto_on = 1'b0;
      checks++;
      if (!ok || got.size() != 9) begin
         errors++;
         $display("FAIL fill_drain ok=%b writes=%0d want 9", ok, got.size());
      end
      for (int i = 0; i < 9 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL fill_order %0d got %h want %h", i, got[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_coalesce();
      bit ok;
      got.delete(); auto_on = 1'b0;
      do_store(32'h40, 32'h11223344, 4'hF, 1'b1);
      do_store(32'h40, 32'hAABBCCDD, 4'h3, 1'b0);
      checks++;
      if ({dc.stb2dcache_req, dc.stb2dcache_w_en, dc.stb2dcache_wdata,
           dc.stb2dcache_sel_byte, dc.dmem_sel_o} !== {2'b11, 32'h1122CCDD, 4'hF, 1'b1}) begin
         errors++;
         $display("FAIL coal_head got req=%b data=%h sel=%h m=%b want 1 1122ccdd f 1",
                  dc.stb2dcache_req, dc.stb2dcache_wdata,
                  dc.stb2dcache_sel_byte, dc.dmem_sel_o);
      end
      auto_on = 1'b1;
      wait_empty(ok);
      auto_on = 1'b0;
      checks++;
      if (!ok || got.size() != 1 ||
          got[0] !== {32'h40, 32'h1122CCDD, 4'hF, 1'b1}) begin
         errors++;
         $display("FAIL coal_single ok=%b writes=%0d want 1 write 1122ccdd",
                  ok, got.size());
      end
      got.delete();
      do_store(32'h40, 32'h11223344, 4'hF, 1'b0);
      tick(); tick();
      checks++;
      if (dc.stb2dcache_req !== 1'b1) begin
         errors++;
         $display("FAIL coal_inflight_req got %b want 1", dc.stb2dcache_req);
      end
      do_store(32'h40, 32'hAABBCCDD, 4'h3, 1'b0);
      auto_on = 1'b1;
      wait_empty(ok);
      auto_on = 1'b0;
      checks++;
      if (!ok || got.size() != 2) begin
         errors++;
         $display("FAIL coal_inflight_cnt ok=%b writes=%0d want 2", ok, got.size());
      end else if (got[0] !== {32'h40, 32'h11223344, 4'hF, 1'b0} ||
                   got[1] !== {32'h40, 32'hAABBCCDD, 4'h3, 1'b0}) begin
         errors++;
         $display("FAIL coal_inflight_data got %h %h want separate writes",
                  got[0], got[1]);
      end
   endtask

   task automatic test_forward();
      bit ok;
      got.delete(); auto_on = 1'b0;
      do_store(32'h80, 32'hDEADBEEF, 4'hF, 1'b0);
      ld_addr = 32'h80; ld_sel = 4'h3; #1;
      checks++;
      if ({fhit, fconf, fdata} !== {2'b10, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL fwd_hit got h=%b c=%b d=%h want 1 0 deadbeef", fhit, fconf, fdata);
      end
      ld_sel = 4'h0; #1;
      checks++;
      if ({fhit, fconf, fdata} !== 34'd0) begin
         errors++;
         $display("FAIL fwd_nosel got h=%b c=%b d=%h want 0 0 0", fhit, fconf, fdata);
      end
      do_store(32'h84, 32'h000000AA, 4'h1, 1'b0);
      ld_addr = 32'h84; ld_sel = 4'h3; #1;
      checks++;
      if ({fhit, fconf, fdata} !== {2'b01, 32'h0}) begin
         errors++;
         $display("FAIL fwd_conflict got h=%b c=%b d=%h want 0 1 0", fhit, fconf, fdata);
      end
      ld_addr = 32'h88; ld_sel = 4'hF; #1;
      checks++;
      if ({fhit, fconf} !== 2'b00) begin
         errors++;
         $display("FAIL fwd_miss got h=%b c=%b want 0 0", fhit, fconf);
      end
      do_store(32'h86, 32'h0000BB00, 4'h2, 1'b0);
      ld_addr = 32'h84; ld_sel = 4'h3; #1;
      checks++;
      if ({fhit, fconf, fdata} !== {2'b10, 32'h0000BBAA}) begin
         errors++;
         $display("FAIL fwd_merged got h=%b c=%b d=%h want 1 0 0000bbaa", fhit, fconf, fdata);
      end
      do_store(32'h80, 32'h00000055, 4'h1, 1'b0);
      ld_addr = 32'h80; ld_sel = 4'h3; #1;
      checks++;
      if ({fhit, fconf} !== 2'b01) begin
         errors++;
         $display("FAIL fwd_youngest got h=%b c=%b want 0 1", fhit, fconf);
      end
      ld_sel = 4'h1; #1;
      checks++;
      if ({fhit, fdata} !== {1'b1, 32'h00000055}) begin
         errors++;
         $display("FAIL fwd_youngest_hit got h=%b d=%h want 1 00000055", fhit, fdata);
      end
      ld_sel = 4'h0;
      auto_on = 1'b1;
      wait_empty(ok);
      auto_on = 1'b0;
      checks++;
      if (!ok || got.size() != 3) begin
         errors++;
         $display("FAIL fwd_drain ok=%b writes=%0d want 3", ok, got.size());
      end
      ld_addr = 32'h80; ld_sel = 4'hF; #1;
      checks++;
      if ({fhit, fconf} !== 2'b00) begin
         errors++;
         $display("FAIL fwd_after_drain got h=%b c=%b want 0 0", fhit, fconf);
      end
      ld_sel = 4'h0;
   endtask

   task automatic test_wrap_random();
      logic [31:0] a, d, w, prev;
      logic [3:0]  s;
      logic        m;
      bit acc, ok;
      got.delete(); exp_q.delete();
      auto_on = 1'b1; ack_max = 3;
      prev = 32'hFFFF_FFFF;
      for (int i = 0; i < 20; i++) begin
         do w = 32'($urandom_range(0, 63)); while (w == prev);
         prev = w;
         a = (w << 2) | 32'($urandom_range(0, 3));
         d = $urandom;
         s = 4'($urandom_range(1, 15));
         m = 1'($urandom_range(0, 1));
         st_addr = a; st_data = d; st_sel = s; st_dmem = m;
         st_req = 1'b1; st_wen = 1'b1;
         acc = 1'b0;
         for (int n = 0; n < 40 && !acc; n++) begin
            tick();
            if (sack === 1'b1) acc = 1'b1;
         end
         st_req = 1'b0; st_wen = 1'b0;
         checks++;
         if (!acc) begin
            errors++;
            $display("FAIL rnd_accept store %0d got no ack want ack", i);
         end else begin
            exp_q.push_back({a, d, s, m});
            ld_addr = a; ld_sel = s; #1;
            checks++;
            if ({fhit, fdata} !== {1'b1, d}) begin
               errors++;
               $display("FAIL rnd_fwd store %0d got h=%b d=%h want 1 %h", i, fhit, fdata, d);
            end
            ld_sel = 4'h0;
         end
         repeat ($urandom_range(0, 2)) tick();
      end
      wait_empty(ok);
      auto_on = 1'b0;
      checks++;
      if (!ok || got.size() != exp_q.size()) begin
         errors++;
         $display("FAIL rnd_drain ok=%b writes=%0d want %0d", ok, got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rnd_order %0d got %h want %h", i, got[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      bit ok;
      got.delete(); auto_on = 1'b0;
      do_store(32'h100, 32'h12345678, 4'hF, 1'b0);
      tick();
      checks++;
      if (dc.stb2dcache_req !== 1'b1) begin
         errors++;
         $display("FAIL midrst_pre_req got %b want 1", dc.stb2dcache_req);
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if ({dc.stb2dcache_req, dc.stb2dcache_empty} !== 2'b01) begin
         errors++;
         $display("FAIL midrst_req_empty got %b want 01",
                  {dc.stb2dcache_req, dc.stb2dcache_empty});
      end
      rst_n = 1'b1; man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      checks++;
      if ({dc.stb2dcache_empty, dc.stb2dcache_req, stall} !== 3'b100) begin
         errors++;
         $display("FAIL midrst_stray_ack got e/r/st=%b want 100",
                  {dc.stb2dcache_empty, dc.stb2dcache_req, stall});
      end
      do_store(32'h104, 32'hCAFEF00D, 4'h3, 1'b1);
      ld_addr = 32'h100; ld_sel = 4'hF; #1;
      checks++;
      if ({fhit, fconf} !== 2'b00) begin
         errors++;
         $display("FAIL midrst_discard got h=%b c=%b want 0 0", fhit, fconf);
      end
      ld_sel = 4'h0;
      auto_on = 1'b1;
      wait_empty(ok);
      auto_on = 1'b0;
      checks++;
      if (!ok || got.size() != 1 || got[0] !== {32'h104, 32'hCAFEF00D, 4'h3, 1'b1}) begin
         errors++;
         $display("FAIL midrst_after ok=%b writes=%0d want 1 write cafef00d",
                  ok, got.size());
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_coalesce();
      test_forward();
      test_wrap_random();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
